// File: rtl/uart_tx_fifo_if.sv
// Byte-stream handshake between a producer and uart_tx_fifo.
//   s_valid : producer has a payload word on s_data
//   s_ready : transmitter FIFO can accept a word this cycle
//   s_data  : payload word, DATA_BITS wide, sent LSB first
// A transfer happens on any rising clock edge with s_valid && s_ready.
// master = producer side, slave = transmitter side.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DATA_BITS-1:0] s_data;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter with an input FIFO and a run-time selectable frame format
// (DATA_BITS payload bits, optional even/odd parity, one or two stop bits).
// Bit timing comes from the shared one-tick-per-bit baud enable.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick         : baud enable, one clk-wide pulse per bit period
//   s            : producer stream (slave modport: s_valid, s_ready, s_data)
//   parity_mode  : 00 none, 01 even, 10 odd, 11 none; latched per frame
//   two_stop     : 1 = two stop bits; latched per frame
//   tx           : serial line, idle high
//   busy         : frame in progress (start through last stop bit)
//   fifo_count   : words waiting in the FIFO (frame in flight not counted)
//   frame_done   : one-cycle pulse at the end of the last stop bit
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    uart_tx_fifo_if.slave    s,
    input  logic [1:0]       parity_mode,
    input  logic             two_stop,
    output logic             tx,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             frame_done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO (registered, head word visible to the FSM without delay)
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ready_q;
    logic                 push, pop, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign push       = s.s_valid && ready_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset: clearing the pointers discards its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s.s_data;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    // s_ready is computed from the next count so it stays aligned with
    // fifo_count while both are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_d;
            ready_q <= (count_d != CNT_W'(FIFO_DEPTH));
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [IDX_W-1:0]     idx_nxt;
    logic [1:0]           pmode_q, pmode_d;
    logic                 two_q, two_d;
    logic                 stop2_q, stop2_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 start_frame;
    logic                 parity_en;
    logic                 parity_bit;

    assign idx_nxt    = idx_q + IDX_W'(1);
    assign parity_en  = (pmode_q == 2'b01) || (pmode_q == 2'b10);
    assign parity_bit = (^data_q) ^ (pmode_q == 2'b10);

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        idx_d       = idx_q;
        pmode_d     = pmode_q;
        two_d       = two_q;
        stop2_d     = stop2_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_frame = 1'b0;

        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (!fifo_empty) begin
                    start_frame = 1'b1;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = data_q[0];
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (idx_q == LAST_IDX) begin
                        if (parity_en) begin
                            state_d = S_PARITY;
                            tx_d    = parity_bit;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                            stop2_d = 1'b0;
                        end
                    end else begin
                        idx_d = idx_nxt;
                        tx_d  = data_q[idx_nxt];
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    stop2_d = 1'b0;
                end
            end
            S_STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (two_q && !stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (!fifo_empty) begin
                            start_frame = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Frame setup shared by the idle launch and the back-to-back launch
        // at the end of a stop bit; the frame format is captured here so
        // later changes on the config inputs only affect the next frame.
        if (start_frame) begin
            data_d  = mem_q[rd_ptr_q];
            pmode_d = parity_mode;
            two_d   = two_stop;
            stop2_d = 1'b0;
            state_d = S_START;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end
    end

    assign pop = start_frame;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            idx_q   <= '0;
            pmode_q <= 2'b00;
            two_q   <= 1'b0;
            stop2_q <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            pmode_q <= pmode_d;
            two_q   <= two_d;
            stop2_q <= stop2_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s.s_ready  = ready_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;
    assign frame_done = done_q;

endmodule
